// File: rtl/alarm_clock_ctrl.sv
// ---- alarm_clock_ctrl : BCD time-of-day / alarm sequencer with set and ring modes ----
// ---- rev 1.0 ----
`timescale 1ns/1ps
`default_nettype none

module alarm_clock_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int RING_SECS = 60
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [3:0] buttons,
  input  logic       switch,
  output logic [3:0] hour_tens,
  output logic [3:0] hour_units,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic [9:0] leds,
  output logic       buzzer
);

  localparam int             PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_TOP = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]  PRESC_HALF = PW'(TICK_DIV / 2);
  localparam logic [7:0]     RING_LIM  = 8'(RING_SECS);

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    SET_T_HR  = 3'd1,
    SET_T_MIN = 3'd2,
    SET_A_HR  = 3'd3,
    SET_A_MIN = 3'd4,
    RING      = 3'd5
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc;
  logic [7:0]    hr, mn, sc, ahr, amn;
  logic [7:0]    hr_n, mn_n, sc_n, ahr_n, amn_n;
  logic [7:0]    ring_cnt, ring_n;
  logic [3:0]    btn_s1, btn_s2, btn_s3;
  logic          sw_s1, sw_s2;

  logic [3:0]    press;
  logic          p_stop, p_mode, p_next, p_inc;
  logic          tick, advance;
  logic [7:0]    hr_a, mn_a, sc_a;

  // Two-digit BCD increment that wraps to 00 after lim.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v == lim)
      bcd_inc = 8'h00;
    else if (v[3:0] == 4'd9)
      bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else
      bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    press   = btn_s3 & ~btn_s2;
    p_stop  = press[3];
    p_mode  = press[0] & ~press[3];
    p_next  = press[2] & ~press[3] & ~press[0];
    p_inc   = press[1] & ~press[3] & ~press[0] & ~press[2];
    tick    = (presc == PRESC_TOP);
    advance = tick && (state != SET_T_HR) && (state != SET_T_MIN);

    sc_a = advance ? bcd_inc(sc, 8'h59) : sc;
    mn_a = (advance && sc == 8'h59) ? bcd_inc(mn, 8'h59) : mn;
    hr_a = (advance && sc == 8'h59 && mn == 8'h59) ? bcd_inc(hr, 8'h23) : hr;

    state_n = state;
    hr_n    = hr_a;
    mn_n    = mn_a;
    sc_n    = sc_a;
    ahr_n   = ahr;
    amn_n   = amn;
    ring_n  = ring_cnt;

    case (state)
      RUN: begin
        if (p_mode) begin
          state_n = SET_T_HR;
          sc_n    = 8'h00;
        end else if (advance && sw_s2 && {hr_a, mn_a, sc_a} == {ahr, amn, 8'h00}) begin
          state_n = RING;
          ring_n  = 8'd0;
        end
      end
      SET_T_HR: begin
        if (p_mode)      state_n = RUN;
        else if (p_next) state_n = SET_T_MIN;
        else if (p_inc)  hr_n = bcd_inc(hr, 8'h23);
      end
      SET_T_MIN: begin
        if (p_mode)      state_n = RUN;
        else if (p_next) state_n = SET_A_HR;
        else if (p_inc)  mn_n = bcd_inc(mn, 8'h59);
      end
      SET_A_HR: begin
        if (p_mode)      state_n = RUN;
        else if (p_next) state_n = SET_A_MIN;
        else if (p_inc)  ahr_n = bcd_inc(ahr, 8'h23);
      end
      SET_A_MIN: begin
        if (p_mode || p_next) state_n = RUN;
        else if (p_inc)       amn_n = bcd_inc(amn, 8'h59);
      end
      RING: begin
        // sw_s1 is the value sw_s2 takes on this edge, so the exit lands with leds[0]
        if (p_stop || !sw_s1) begin
          state_n = RUN;
        end else if (tick) begin
          ring_n = ring_cnt + 8'd1;
          if (ring_cnt + 8'd1 == RING_LIM) state_n = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state    <= RUN;
      presc    <= '0;
      hr       <= 8'h00;
      mn       <= 8'h00;
      sc       <= 8'h00;
      ahr      <= 8'h00;
      amn      <= 8'h00;
      ring_cnt <= 8'd0;
      btn_s1   <= 4'hF;
      btn_s2   <= 4'hF;
      btn_s3   <= 4'hF;
      sw_s1    <= 1'b0;
      sw_s2    <= 1'b0;
    end else begin
      state    <= state_n;
      presc    <= tick ? '0 : presc + 1'b1;
      hr       <= hr_n;
      mn       <= mn_n;
      sc       <= sc_n;
      ahr      <= ahr_n;
      amn      <= amn_n;
      ring_cnt <= ring_n;
      btn_s1   <= buttons;
      btn_s2   <= btn_s1;
      btn_s3   <= btn_s2;
      sw_s1    <= switch;
      sw_s2    <= sw_s1;
    end
  end

  logic set_t, set_a;
  assign set_t = (state == SET_T_HR) || (state == SET_T_MIN);
  assign set_a = (state == SET_A_HR) || (state == SET_A_MIN);

  assign {hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units} =
         set_a ? {ahr, amn, 8'h00} : {hr, mn, sc};

  assign leds   = {5'b00000, presc < PRESC_HALF, set_a, set_t, state == RING, sw_s2};
  assign buzzer = (state == RING);

endmodule

`default_nettype wire

// File: tb/tb_alarm_clock_ctrl.sv
// Bench for alarm_clock_ctrl: seconds-of-day reference model plus directed scenarios.
`timescale 1ns/1ps
`default_nettype none

module tb_alarm_clock_ctrl;

  localparam int TD = 10;
  localparam int RS = 5;
  localparam logic [3:0] B_MODE = 4'b0001;
  localparam logic [3:0] B_INC  = 4'b0010;
  localparam logic [3:0] B_NEXT = 4'b0100;
  localparam logic [3:0] B_STOP = 4'b1000;
  localparam int M_RUN = 0, M_STH = 1, M_STM = 2, M_SAH = 3, M_SAM = 4, M_RING = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] buttons = 4'hF;
  logic       switch = 1'b0;
  logic [3:0] hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units;
  logic [9:0] leds;
  logic       buzzer;
  logic [23:0] dig;

  int n_pass = 0;
  int n_chk  = 0;

  alarm_clock_ctrl #(.TICK_DIV(TD), .RING_SECS(RS)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .buttons(buttons), .switch(switch),
    .hour_tens(hour_tens), .hour_units(hour_units), .min_tens(min_tens),
    .min_units(min_units), .sec_tens(sec_tens), .sec_units(sec_units),
    .leds(leds), .buzzer(buzzer)
  );

  assign dig = {hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units};

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: time as seconds of day, alarm as minutes of day.
  int m_t, m_a, m_mode, m_presc, m_rc;
  logic [3:0] bh1, bh2, bh3, m_fell;
  logic sw1m, sw2m;
  bit m_valid = 0;
  bit m_tk, m_ps, m_pm, m_pn, m_pi;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0; m_a = 0; m_mode = M_RUN; m_presc = 0; m_rc = 0;
      bh1 = 4'hF; bh2 = 4'hF; bh3 = 4'hF; sw1m = 0; sw2m = 0;
      m_valid = 1;
    end else begin
      m_fell = bh3 & ~bh2;
      m_ps = m_fell[3];
      m_pm = m_fell[0] && !m_ps;
      m_pn = m_fell[2] && !m_ps && !m_pm;
      m_pi = m_fell[1] && !m_ps && !m_pm && !m_pn;
      m_tk = (m_presc == TD - 1);
      case (m_mode)
        M_RUN: begin
          if (m_pm) begin
            if (m_tk) m_t = (m_t + 1) % 86400;
            m_t = m_t - m_t % 60;
            m_mode = M_STH;
          end else if (m_tk) begin
            m_t = (m_t + 1) % 86400;
            if (sw2m && m_t == m_a * 60) begin m_mode = M_RING; m_rc = 0; end
          end
        end
        M_STH: begin
          if (m_pm) m_mode = M_RUN;
          else if (m_pn) m_mode = M_STM;
          else if (m_pi) m_t = ((m_t / 3600 + 1) % 24) * 3600 + m_t % 3600;
        end
        M_STM: begin
          if (m_pm) m_mode = M_RUN;
          else if (m_pn) m_mode = M_SAH;
          else if (m_pi) m_t = (m_t / 3600) * 3600 + ((m_t / 60 % 60 + 1) % 60) * 60 + m_t % 60;
        end
        M_SAH, M_SAM: begin
          if (m_tk) m_t = (m_t + 1) % 86400;
          if (m_pm) m_mode = M_RUN;
          else if (m_pn) m_mode = (m_mode == M_SAH) ? M_SAM : M_RUN;
          else if (m_pi) begin
            if (m_mode == M_SAH) m_a = ((m_a / 60 + 1) % 24) * 60 + m_a % 60;
            else                 m_a = (m_a / 60) * 60 + (m_a % 60 + 1) % 60;
          end
        end
        default: begin
          if (m_tk) m_t = (m_t + 1) % 86400;
          if (m_ps || !sw1m) m_mode = M_RUN;
          else if (m_tk) begin
            m_rc++;
            if (m_rc == RS) m_mode = M_RUN;
          end
        end
      endcase
      bh3 = bh2; bh2 = bh1; bh1 = buttons;
      sw2m = sw1m; sw1m = switch;
      m_presc = (m_presc + 1) % TD;
    end
  end

  function automatic logic [23:0] bcd_time(input int s);
    int h, m, c;
    h = s / 3600; m = (s / 60) % 60; c = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  logic [34:0] exp_vec;
  always @(negedge clk) begin
    if (m_valid) begin
      exp_vec[34:11] = (m_mode == M_SAH || m_mode == M_SAM) ? bcd_time(m_a * 60) : bcd_time(m_t);
      exp_vec[10:1]  = {5'b00000, m_presc < TD / 2, m_mode == M_SAH || m_mode == M_SAM,
                        m_mode == M_STH || m_mode == M_STM, m_mode == M_RING, sw2m};
      exp_vec[0]     = (m_mode == M_RING);
      chk("cycle", 64'({dig, leds, buzzer}), 64'(exp_vec));
    end
  end

  task automatic press(input logic [3:0] mask);
    @(negedge clk) buttons = ~mask;
    repeat (3) @(negedge clk);
    buttons = 4'hF;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_buzz(input int maxc, input string nm);
    bit ok = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(posedge clk); #1;
      if (buzzer) ok = 1;
    end
    chk(nm, 64'(ok), 64'd1);
  endtask

  task automatic goto_sam();
    press(B_MODE); press(B_NEXT); press(B_NEXT); press(B_NEXT);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit seen;
    repeat (3) @(negedge clk);
    chk("rst_digits", 64'(dig), 64'h0);
    chk("rst_leds", 64'(leds), 64'h010);
    chk("rst_buzzer", 64'(buzzer), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    repeat (600) @(posedge clk); #1;
    chk("count_1min", 64'(dig), 64'h000100);

    press(B_MODE);
    repeat (24) press(B_INC);
    chk("hr_wrap", 64'(dig), 64'h000100);
    repeat (23) press(B_INC);
    press(B_NEXT);
    repeat (58) press(B_INC);
    chk("set_2359", 64'(dig), 64'h235900);
    press(B_INC);
    chk("min_wrap", 64'(dig), 64'h230000);
    repeat (59) press(B_INC);
    press(B_MODE);
    repeat (598) @(posedge clk); #1;
    chk("rollover", 64'(dig), 64'h000000);

    switch = 1'b1;
    goto_sam();
    chk("alarm_disp0", 64'(dig), 64'h000000);
    press(B_INC); press(B_INC);
    chk("alarm_0002", 64'(dig), 64'h000200);
    press(B_NEXT);
    press(B_MODE); press(B_NEXT); press(B_INC);
    chk("time_0001", 64'(dig), 64'h000100);
    press(B_MODE);
    wait_buzz(1400, "ring_start");
    chk("ring_time", 64'(dig), 64'h000200);
    chk("ring_led", 64'(leds[1]), 64'd1);

    @(negedge clk) buttons = ~B_STOP;
    @(posedge clk); @(posedge clk); #1;
    chk("stop_lat", 64'(buzzer), 64'd1);
    @(posedge clk); #1;
    chk("stop", 64'(buzzer), 64'd0);
    @(negedge clk) buttons = 4'hF;
    repeat (2) @(negedge clk);

    goto_sam(); press(B_INC); press(B_NEXT);
    wait_buzz(800, "ring2_start");
    repeat (49) @(posedge clk); #1;
    chk("ring_4ticks", 64'(buzzer), 64'd1);
    @(posedge clk); #1;
    chk("ring_timeout", 64'(buzzer), 64'd0);

    @(negedge clk) switch = 1'b0;
    goto_sam(); press(B_INC); press(B_NEXT);
    seen = 0;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      if (buzzer) seen = 1;
    end
    chk("gated_no_ring", 64'(seen), 64'd0);

    @(negedge clk) switch = 1'b1;
    goto_sam(); press(B_INC); press(B_NEXT);
    wait_buzz(800, "ring3_start");
    @(negedge clk) switch = 1'b0;
    @(posedge clk); #1;
    chk("swdrop_lat", 64'(buzzer), 64'd1);
    @(posedge clk); #1;
    chk("swdrop_exit", 64'(buzzer), 64'd0);
    chk("swdrop_led0", 64'(leds[0]), 64'd0);
    @(negedge clk) switch = 1'b1;

    press(B_MODE); press(B_NEXT); press(B_NEXT);
    chk("sah_disp", 64'(dig), 64'h000500);
    do @(negedge clk); while (m_presc != 7);
    buttons = ~B_INC;
    repeat (3) @(negedge clk);
    buttons = 4'hF;
    repeat (2) @(negedge clk);
    chk("coinc_ah", 64'(dig), 64'h010500);
    press(B_NEXT);
    chk("sam_disp", 64'(dig), 64'h010500);
    press(B_MODE | B_INC);
    chk("prio_run", 64'(leds[3:1]), 64'd0);
    goto_sam();
    chk("prio_am_kept", 64'(dig), 64'h010500);

    press(B_NEXT);
    press(B_MODE); press(B_NEXT); press(B_NEXT);
    repeat (23) press(B_INC);
    chk("ah_wrap", 64'(dig), 64'h000500);
    press(B_NEXT);
    n = ((m_t / 60) % 60 + 2 - 5 + 60) % 60;
    repeat (n) press(B_INC);
    press(B_NEXT);
    wait_buzz(1500, "ring4_start");

    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_buzzer", 64'(buzzer), 64'd0);
    chk("arst_digits", 64'(dig), 64'h0);
    chk("arst_leds", 64'(leds), 64'h010);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alarm_clock_ctrl.md
# alarm_clock_ctrl

Sequencing controller for the timer-with-clock system. It keeps the time of day and the alarm time as BCD registers and runs the set-time / set-alarm / ringing state machine from the four board buttons and the alarm switch. It drives the six BCD digits to the seven-segment decoders, plus the buzzer and LED exports. One instance sits between the board I/O and the display/buzzer peripherals.

## Interface
- TICK_DIV, 50000000 — clock cycles per second; minimum 4, even.
- RING_SECS, 60 — maximum ring duration in seconds; range 1..255.
- clk_clk  in  1 — system clock; the only clock.
- reset_reset_n  in  1 — asynchronous, active-low reset.
- buttons  in  4 — raw board keys, active-low (0 = pressed), already debounced. [0] = mode, [1] = increment, [2] = next field, [3] = stop.
- switch  in  1 — alarm enable (1 = armed); asynchronous, 2-flop synchronized.
- hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units  out  4 each — BCD display digits.
- leds  out  10 — status LEDs.
- buzzer  out  1 — 1 = sound.

## Operation
- Prescaler counts 0..TICK_DIV-1 and wraps. `tick` is a one-cycle pulse when the count equals TICK_DIV-1.
- Time register hh:mm:ss in BCD. On tick it advances ss 59→00 with carry into mm, mm 59→00 with carry into hh, and 23:59:59→00:00:00.
- Alarm register ah:am in BCD.
- Buttons are 2-flop synchronized, then falling-edge detected to give a one-cycle `press`.
  - Priority when several presses land in the same cycle: stop > mode > next > increment. Lower-priority presses are discarded.
- States and transitions:
  - RUN: the time advances. Mode → SET_T_HR. Increment, next and stop are ignored.
  - SET_T_HR → (next) SET_T_MIN → (next) SET_A_HR → (next) SET_A_MIN → (next) RUN.
    - Mode in any SET state → RUN.
    - Stop in any SET state is ignored.
  - SET_T_HR / SET_T_MIN:
    - The time is frozen; tick is ignored.
    - ss is forced to 00 on the edge that enters SET_T_HR.
    - Increment adds 1 to hh (23→00) or mm (59→00), with no carry into any other field.
  - SET_A_HR / SET_A_MIN:
    - The time keeps advancing on tick.
    - Increment adds 1 to ah (23→00) or am (59→00).
    - A tick and an increment in the same cycle are both applied.
  - RING:
    - The time keeps advancing and buzzer = 1.
    - Ring counter starts at 0 on entry and increments on each tick.
    - Exit to RUN on the first of: stop press, switch synchronized to 0, or ring counter reaching RING_SECS.
    - Mode, next and increment are ignored.
- Alarm match:
  - Condition: in RUN, a tick produces a new time equal to ah:am:00 while switch (synchronized) = 1.
  - The block enters RING on the same edge that loads that new time.
  - No match is possible in any other state. Reset never triggers a match.
- Display:
  - In SET_A_HR and SET_A_MIN the digits show ah:am:00.
  - Otherwise they show the time register.
- LEDs:
  - [0] = synchronized switch.
  - [1] = RING.
  - [2] = SET_T_HR or SET_T_MIN.
  - [3] = SET_A_HR or SET_A_MIN.
  - [4] = 1 while prescaler < TICK_DIV/2.
  - [9:5] = 0.

## Timing
- Reset values:
  - State RUN; time 00:00:00; alarm 00:00; prescaler 0; ring counter 0.
  - All synchronizer flops for buttons reset to 1; switch synchronizer flops reset to 0.
  - All digits 0, leds = 10'b0000010000 (prescaler 0 < TICK_DIV/2), buzzer 0.
  - Reset asserted mid-operation, including during RING, returns all of the above immediately and asynchronously.
- All outputs are registered or decoded only from registers; there is no combinational path from inputs.
- Button latency:
  - A key sampled low at edge N acts at edge N+2.
  - Its effect is visible on outputs after edge N+2.
  - A held key produces exactly one press. Release produces nothing.
- Switch latency: 2 edges to leds[0] and to the RING-exit condition.
- Tick:
  - The time updates on the edge where the prescaler wraps TICK_DIV-1→0.
  - The first tick after reset lands at edge TICK_DIV.
- RING to RUN: buzzer falls on the same edge as the exit condition is registered.
- The prescaler is never cleared by mode changes.

## Test plan
Parameters for all scenarios: TICK_DIV=10, RING_SECS=5.
- **Reset/count:** release reset, run 600 cycles → digits read 00:01:00, leds[4] toggles every 5 cycles, buzzer 0.
- **Rollover:** set time to 23:59 via SET_T_HR (23 increments) and SET_T_MIN (59 increments), return to RUN, run 60 ticks → 00:00:00. Hour and minute increments wrap at 24 and 60 with no carry into other fields.
- **Alarm ring and stop:**
  - Setup: alarm 00:02, switch=1, time 00:01:58.
  - After 2 ticks → RING on the edge where the time becomes 00:02:00, buzzer=1, leds[1]=1.
  - Stop pressed → buzzer 0 at press edge +2.
- **Ring timeout and switch gating:**
  - Unattended ring → buzzer low after exactly 5 ticks.
  - With switch=0 the same match → no RING.
  - Switch dropped during RING → RUN within 2 edges.
- **Priority/simultaneity:**
  - Mode and increment pressed in the same cycle in SET_A_MIN → RUN, am unchanged.
  - Increment coincident with tick in SET_A_HR → ah+1 and ss+1 both applied.
- **Async reset mid-RING:** assert reset_reset_n=0 while ringing → buzzer 0, state RUN, time 00:00:00 with no clock edge required.
